// File: rtl/morph_pkg.sv
// Shared types for the 3x3 binary morphology stream and later filter stages.
package morph_pkg;

  typedef enum logic [1:0] {
    OP_PASS   = 2'b00,
    OP_ERODE  = 2'b01,
    OP_DILATE = 2'b10,
    OP_EDGE   = 2'b11
  } morph_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FILL  = 2'b01,
    S_RUN   = 2'b10,
    S_FLUSH = 2'b11
  } morph_state_t;

  // 3x3 neighbourhood, bit index = row*3 + col, row 0 = line above centre
  typedef logic [8:0] window_t;

  localparam int WIN_CENTRE = 4;

endpackage

// File: rtl/morph_kernel.sv
// Combinational 3x3 binary morphology on an already border-masked window.
module morph_kernel
  import morph_pkg::*;
(
  input  window_t   win,
  input  morph_op_t op,
  output logic      pixel
);

  logic ero, dil;

  assign ero = &win;
  assign dil = |win;

  always_comb begin
    pixel = 1'b0;
    case (op)
      OP_PASS:   pixel = win[WIN_CENTRE];
      OP_ERODE:  pixel = ero;
      OP_DILATE: pixel = dil;
      OP_EDGE:   pixel = dil & ~ero;
      default:   pixel = 1'b0;
    endcase
  end

endmodule

// File: rtl/morph_stream.sv
// Streaming 3x3 binary morphology: line shift register, border masking, FSM and
// a valid/ready output register. Output k is produced as input k+W+1 is accepted.
module morph_stream
  import morph_pkg::*;
#(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 128
) (
  input  logic      clock,
  input  logic      reset_n,
  input  morph_op_t op,
  input  logic      in_valid,
  output logic      in_ready,
  input  logic      in_pixel,
  input  logic      in_sof,
  output logic      out_valid,
  input  logic      out_ready,
  output logic      out_pixel,
  output logic      out_sof,
  output logic      out_eof,
  output logic      busy
);

  localparam int SR_LEN = 2*IMG_WIDTH + 3;
  localparam int CW     = $clog2(IMG_WIDTH);
  localparam int RW     = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  morph_state_t      state;
  morph_op_t         op_q;
  // Oldest tap is read from the next-value view, so the register itself is one bit shorter.
  logic [SR_LEN-2:0] sr;
  logic [SR_LEN-1:0] sr_nxt;
  logic [CW-1:0]     in_col, out_col;
  logic [RW-1:0]     in_row, out_row;

  logic    adv, in_acc, eof_held, flush_step, shift, load, kpix;
  logic    top_ok, bot_ok, lft_ok, rgt_ok;
  window_t win, mask, win_m;

  assign adv = !out_valid || out_ready;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_IDLE, S_FILL: in_ready = 1'b1;
      S_RUN:          in_ready = adv;
      default:        in_ready = 1'b0;
    endcase
  end

  assign in_acc     = in_valid && in_ready;
  assign eof_held   = out_valid && out_eof;
  assign flush_step = (state == S_FLUSH) && adv && !eof_held;
  assign shift      = flush_step || (in_acc && (state != S_IDLE || in_sof));
  assign load       = flush_step || ((state == S_RUN) && in_acc);
  assign sr_nxt     = {sr, (state == S_FLUSH) ? 1'b0 : in_pixel};

  // Border validity of the centre pixel's neighbours; also blocks row wrap.
  assign top_ok = (out_row != '0);
  assign bot_ok = (out_row != ROW_LAST);
  assign lft_ok = (out_col != '0);
  assign rgt_ok = (out_col != COL_LAST);

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      localparam bit CHK_T = (r == 0);
      localparam bit CHK_B = (r == 2);
      localparam bit CHK_L = (c == 0);
      localparam bit CHK_R = (c == 2);
      assign win[r*3+c]  = sr_nxt[(2-r)*IMG_WIDTH + (2-c)];
      assign mask[r*3+c] = (!CHK_T || top_ok) && (!CHK_B || bot_ok) &&
                           (!CHK_L || lft_ok) && (!CHK_R || rgt_ok);
    end
  end

  assign win_m = win & mask;

  morph_kernel u_kernel (
    .win   (win_m),
    .op    (op_q),
    .pixel (kpix)
  );

  assign busy = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_q      <= OP_PASS;
      sr        <= '0;
      in_col    <= '0;
      in_row    <= '0;
      out_col   <= '0;
      out_row   <= '0;
      out_valid <= 1'b0;
      out_pixel <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      if (shift) sr <= sr_nxt[SR_LEN-2:0];

      case (state)
        S_IDLE: begin
          if (in_valid && in_sof) begin
            op_q    <= op;
            in_col  <= CW'(1);
            in_row  <= '0;
            out_col <= '0;
            out_row <= '0;
            state   <= S_FILL;
          end
        end
        S_FILL, S_RUN: begin
          if (in_acc) begin
            if (in_col == COL_LAST) begin
              in_col <= '0;
              in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
            end else begin
              in_col <= in_col + 1'b1;
            end
            if (state == S_FILL && in_row == RW'(1) && in_col == '0)
              state <= S_RUN;
            if (state == S_RUN && in_row == ROW_LAST && in_col == COL_LAST)
              state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (eof_held && out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (load) begin
        out_valid <= 1'b1;
        out_pixel <= kpix;
        out_sof   <= (out_row == '0) && (out_col == '0);
        out_eof   <= (out_row == ROW_LAST) && (out_col == COL_LAST);
        if (out_col == COL_LAST) begin
          out_col <= '0;
          out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_pixel <= 1'b0;
        out_sof   <= 1'b0;
        out_eof   <= 1'b0;
      end
    end
  end

endmodule
